// File: rtl/nibble_serial_add_ctrl_if.sv
// ----------------------------------------------------------------------------
// nibble_serial_add_ctrl_if : request/result and shared-adder bus (rev 1.0)
// ----------------------------------------------------------------------------
`default_nettype none

interface nibble_serial_add_ctrl_if #(
  parameter int NIBBLES = 4
);
  localparam int W = 4 * NIBBLES;

  logic         start;
  logic         sub;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         ready;
  logic         done;
  logic [W-1:0] sum;
  logic         cout;
  logic         ovf;
  logic [3:0]   add_x;
  logic [3:0]   add_y;
  logic         add_cin;
  logic [3:0]   add_s;
  logic         add_cout;

  // Requester plus external adder side
  modport master (
    output start, sub, a, b, add_s, add_cout,
    input  ready, done, sum, cout, ovf, add_x, add_y, add_cin
  );

  // Sequencer side
  modport slave (
    input  start, sub, a, b, add_s, add_cout,
    output ready, done, sum, cout, ovf, add_x, add_y, add_cin
  );
endinterface

`default_nettype wire

// File: rtl/nibble_serial_add_ctrl.sv
// ----------------------------------------------------------------------------
// nibble_serial_add_ctrl : multi-nibble add/sub through one shared 4-bit adder
// rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module nibble_serial_add_ctrl #(
  parameter int NIBBLES = 4
) (
  input  wire                        clk,
  input  wire                        rst_n,
  nibble_serial_add_ctrl_if.slave    bus
);
  localparam int W    = 4 * NIBBLES;
  localparam int IDXW = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
  localparam logic [IDXW-1:0] LAST_IDX = IDXW'(NIBBLES - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t            state;
  state_t            state_nx;
  logic [W-1:0]      a_r;
  logic [W-1:0]      b_r;
  logic              carry_r;
  logic              msb_a;
  logic              msb_b;
  logic [IDXW-1:0]   idx;
  logic [IDXW+1:0]   nib_base;
  logic [W-1:0]      result;
  logic              carry_out;
  logic              overflow;
  logic              last;

  assign nib_base = {idx, 2'b00};
  assign last     = (idx == LAST_IDX);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nx;
    end
  end

  // Adder drive decodes from registered state only, so there is no
  // combinational path from any input to these outputs.
  always_comb begin
    state_nx    = state;
    bus.add_x   = 4'd0;
    bus.add_y   = 4'd0;
    bus.add_cin = 1'b0;
    bus.ready   = 1'b0;
    bus.done    = 1'b0;
    case (state)
      IDLE: begin
        bus.ready = 1'b1;
        if (bus.start) begin
          state_nx = RUN;
        end
      end
      RUN: begin
        bus.add_x   = a_r[nib_base +: 4];
        bus.add_y   = b_r[nib_base +: 4];
        bus.add_cin = carry_r;
        if (last) begin
          state_nx = DONE;
        end
      end
      DONE: begin
        bus.done = 1'b1;
        state_nx = IDLE;
      end
      default: begin
        state_nx = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_r       <= '0;
      b_r       <= '0;
      carry_r   <= 1'b0;
      msb_a     <= 1'b0;
      msb_b     <= 1'b0;
      idx       <= '0;
      result    <= '0;
      carry_out <= 1'b0;
      overflow  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.start) begin
            // Subtract is a + ~b + 1: invert b here, inject the 1 as carry-in.
            a_r       <= bus.a;
            b_r       <= bus.sub ? ~bus.b : bus.b;
            carry_r   <= bus.sub;
            msb_a     <= bus.a[W-1];
            msb_b     <= bus.sub ? ~bus.b[W-1] : bus.b[W-1];
            idx       <= '0;
            result    <= '0;
            carry_out <= 1'b0;
            overflow  <= 1'b0;
          end
        end
        RUN: begin
          result[nib_base +: 4] <= bus.add_s;
          carry_r               <= bus.add_cout;
          idx                   <= idx + 1'b1;
          if (last) begin
            carry_out <= bus.add_cout;
            overflow  <= (msb_a == msb_b) && (bus.add_s[3] != msb_a);
          end
        end
        default: begin
        end
      endcase
    end
  end

  assign bus.sum  = result;
  assign bus.cout = carry_out;
  assign bus.ovf  = overflow;

endmodule

`default_nettype wire
